// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the bounded-repetition sequence checker.
package seq_chk_pkg;

  localparam int CAUSE_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [CAUSE_W-1:0] {
    NONE  = 2'd0,
    BREAK = 2'd1,
    OVER  = 2'd2,
    UNDER = 2'd3
  } cause_t;

endpackage

// File: rtl/seq_rep_chan.sv
// One checker channel for start ##1 cond[*REP_MIN:REP_MAX] ##1 fin.
// The FSM decides in the cycle fin/cond resolves the attempt; the result
// is registered and reported one cycle later as a single-cycle pulse.
module seq_rep_chan
  import seq_chk_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int REP_MIN = 3,
  parameter int REP_MAX = 4,
  parameter int FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic               i_start,
  input  logic               i_cond,
  input  logic               i_fin,
  output logic               o_busy,
  output logic               o_pass,
  output logic               o_fail,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_dropped,
  output logic [FCNT_W-1:0]  o_fcount
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_pass;
  logic               r_fail;
  cause_t             r_cause;
  logic               r_dropped;
  logic [FCNT_W-1:0]  r_fcount;

  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_pass_next;
  logic               w_fail_next;
  cause_t             w_cause_next;
  logic               w_drop_next;
  logic               w_decide;

  logic               w_ge_min;
  logic               w_le_max;
  logic               w_over;
  logic               w_sat;

  // Bound comparisons are resolved at elaboration where a bound makes
  // them trivially true/false, so no constant compares reach synthesis.
  if (REP_MIN == 0) begin : g_min_zero
    assign w_ge_min = 1'b1;
  end else begin : g_min_cmp
    assign w_ge_min = (r_cnt >= CNT_W'(REP_MIN));
  end

  if (REP_MAX == 0) begin : g_unbounded
    assign w_le_max = 1'b1;
    assign w_over   = 1'b0;
  end else begin : g_bounded
    // One extra bit so cnt+1 cannot wrap when REP_MAX is all-ones.
    logic [CNT_W:0] w_cnt_inc;
    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_le_max  = (r_cnt <= CNT_W'(REP_MAX));
    assign w_over    = (w_cnt_inc > (CNT_W + 1)'(REP_MAX));
  end

  assign w_sat = &r_cnt;

  // Next-state, counter and decision logic for the two-state FSM.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pass_next  = 1'b0;
    w_fail_next  = 1'b0;
    w_cause_next = NONE;
    w_drop_next  = 1'b0;
    w_decide     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en && i_start) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end
      end
      RUN: begin
        if (!i_en) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (i_fin) begin
          w_decide = 1'b1;
          if (w_ge_min && w_le_max) begin
            w_pass_next = 1'b1;
          end else begin
            w_fail_next  = 1'b1;
            w_cause_next = UNDER;
          end
        end else if (i_cond) begin
          if (w_over) begin
            w_decide     = 1'b1;
            w_fail_next  = 1'b1;
            w_cause_next = OVER;
          end else if (!w_sat) begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end else begin
          w_decide     = 1'b1;
          w_fail_next  = 1'b1;
          w_cause_next = BREAK;
        end

        // A start in the deciding cycle re-arms; otherwise it is dropped.
        if (w_decide) begin
          w_state_next = i_start ? RUN : IDLE;
          w_cnt_next   = '0;
        end else if (i_en && i_start) begin
          w_drop_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counter and registered result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_cause   <= NONE;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pass    <= w_pass_next;
      r_fail    <= w_fail_next;
      r_cause   <= w_cause_next;
      r_dropped <= w_drop_next;
    end
  end

  // Saturating failure counter fed by the registered fail pulse; clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcount <= '0;
    end else if (i_clr) begin
      r_fcount <= '0;
    end else if (r_fail && !(&r_fcount)) begin
      r_fcount <= r_fcount + 1'b1;
    end
  end

  assign o_busy    = (r_state == RUN);
  assign o_pass    = r_pass;
  assign o_fail    = r_fail;
  assign o_cause   = r_cause;
  assign o_dropped = r_dropped;
  assign o_fcount  = r_fcount;

endmodule

// File: rtl/seq_rep_checker.sv
// Multi-channel bounded consecutive-repetition checker; one independent
// seq_rep_chan per channel with packed output vectors.
module seq_rep_checker
  import seq_chk_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int REP_MIN = 3,
  parameter int REP_MAX = 4,
  parameter int FCNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NCH-1:0]        start,
  input  logic [NCH-1:0]        cond,
  input  logic [NCH-1:0]        fin,
  output logic [NCH-1:0]        busy,
  output logic [NCH-1:0]        pass,
  output logic [NCH-1:0]        fail,
  output logic [CAUSE_W*NCH-1:0] cause,
  output logic [NCH-1:0]        dropped,
  output logic [FCNT_W*NCH-1:0] fcount
);

  // Reject inconsistent or unrepresentable bounds at elaboration.
  if (REP_MAX != 0 && REP_MIN > REP_MAX) begin : g_err_order
    $error("seq_rep_checker: REP_MIN exceeds REP_MAX");
  end
  if (REP_MIN > (2 ** CNT_W) - 1 || REP_MAX > (2 ** CNT_W) - 1) begin : g_err_width
    $error("seq_rep_checker: repetition bound does not fit in CNT_W");
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    seq_rep_chan #(
      .CNT_W   (CNT_W),
      .REP_MIN (REP_MIN),
      .REP_MAX (REP_MAX),
      .FCNT_W  (FCNT_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en),
      .i_clr     (clr),
      .i_start   (start[gi]),
      .i_cond    (cond[gi]),
      .i_fin     (fin[gi]),
      .o_busy    (busy[gi]),
      .o_pass    (pass[gi]),
      .o_fail    (fail[gi]),
      .o_cause   (cause[CAUSE_W*gi +: CAUSE_W]),
      .o_dropped (dropped[gi]),
      .o_fcount  (fcount[FCNT_W*gi +: FCNT_W])
    );
  end

endmodule

// File: tb/tb_seq_rep_checker.sv
// Directed bench: default 3:4 checker, an unbounded 0:$ checker with a
// 3-bit counter, and a 2-bit failure counter instance for saturation.
module tb_seq_rep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance A
  logic        a_en, a_clr;
  logic [3:0]  a_start, a_cond, a_fin;
  logic [3:0]  a_busy, a_pass, a_fail, a_dropped;
  logic [7:0]  a_cause;
  logic [63:0] a_fcount;

  // Unbounded instance B
  logic        b_en, b_clr;
  logic [0:0]  b_start, b_cond, b_fin;
  logic [0:0]  b_busy, b_pass, b_fail, b_dropped;
  logic [1:0]  b_cause;
  logic [15:0] b_fcount;

  // Small failure-counter instance C
  logic        c_en, c_clr;
  logic [0:0]  c_start, c_cond, c_fin;
  logic [0:0]  c_busy, c_pass, c_fail, c_dropped;
  logic [1:0]  c_cause;
  logic [1:0]  c_fcount;

  seq_rep_checker u_dut (
    .clk(clk), .rst_n(rst_n), .en(a_en), .clr(a_clr),
    .start(a_start), .cond(a_cond), .fin(a_fin),
    .busy(a_busy), .pass(a_pass), .fail(a_fail), .cause(a_cause),
    .dropped(a_dropped), .fcount(a_fcount)
  );

  seq_rep_checker #(.NCH(1), .CNT_W(3), .REP_MIN(0), .REP_MAX(0)) u_dut_unb (
    .clk(clk), .rst_n(rst_n), .en(b_en), .clr(b_clr),
    .start(b_start), .cond(b_cond), .fin(b_fin),
    .busy(b_busy), .pass(b_pass), .fail(b_fail), .cause(b_cause),
    .dropped(b_dropped), .fcount(b_fcount)
  );

  seq_rep_checker #(.NCH(1), .FCNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .en(c_en), .clr(c_clr),
    .start(c_start), .cond(c_cond), .fin(c_fin),
    .busy(c_busy), .pass(c_pass), .fail(c_fail), .cause(c_cause),
    .dropped(c_dropped), .fcount(c_fcount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    a_en = 0; a_clr = 0; a_start = 0; a_cond = 0; a_fin = 0;
    b_en = 0; b_clr = 0; b_start = 0; b_cond = 0; b_fin = 0;
    c_en = 0; c_clr = 0; c_start = 0; c_cond = 0; c_fin = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_cause", a_cause, 0);
    chk("rst_dropped", a_dropped, 0);
    chk("rst_fcount", a_fcount, 0);
    rst_n = 1;
    a_en = 1; b_en = 1; c_en = 1;
    tick();

    // ch0: 3 conds then fin -> pass
    a_start = 4'b0001; tick();
    chk("p_busy_t1", a_busy, 4'b0001);
    a_start = 0; a_cond = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p_busy_run", a_busy, 4'b0001);
      chk("p_nopass_run", a_pass, 0);
    end
    a_cond = 0; a_fin = 4'b0001; tick();
    chk("p_pass", a_pass, 4'b0001);
    chk("p_busy_after", a_busy, 0);
    a_fin = 0; tick();
    chk("p_pass_one_cycle", a_pass, 0);

    // ch1: 5 conds -> OVER
    a_start = 4'b0010; tick();
    a_start = 0; a_cond = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("o_nofail_early", a_fail, 0);
    end
    tick();
    chk("o_fail", a_fail, 4'b0010);
    chk("o_cause", a_cause, 8'h08);
    a_cond = 0; tick();
    chk("o_fail_one_cycle", a_fail, 0);
    chk("o_cause_clear", a_cause, 0);
    chk("o_fcount1", a_fcount[31:16], 1);
    chk("o_idle", a_busy, 0);

    // ch2: UNDER then BREAK
    a_start = 4'b0100; tick();
    a_start = 0; a_cond = 4'b0100;
    repeat (2) tick();
    a_cond = 0; a_fin = 4'b0100; tick();
    chk("u_fail", a_fail, 4'b0100);
    chk("u_cause", a_cause, 8'h30);
    a_fin = 0; tick();
    a_start = 4'b0100; tick();
    a_start = 0; a_cond = 4'b0100; tick();
    a_cond = 0; tick();
    chk("b_fail", a_fail, 4'b0100);
    chk("b_cause", a_cause, 8'h10);
    tick();
    chk("b_fcount2", a_fcount[47:32], 2);

    // ch0: back-to-back re-arm, then a dropped start mid-attempt
    a_start = 4'b0001; tick();
    a_start = 0; a_cond = 4'b0001;
    repeat (3) tick();
    a_cond = 0; a_fin = 4'b0001; a_start = 4'b0001; tick();
    chk("bb_pass", a_pass, 4'b0001);
    chk("bb_busy", a_busy, 4'b0001);
    chk("bb_nodrop", a_dropped, 0);
    a_fin = 0; a_cond = 4'b0001; a_start = 4'b0001; tick();
    chk("bb_dropped", a_dropped, 4'b0001);
    a_start = 0; tick();
    chk("bb_drop_one_cycle", a_dropped, 0);
    tick();
    a_cond = 0; a_fin = 4'b0001; tick();
    chk("bb_pass2", a_pass, 4'b0001);
    chk("bb_nofail2", a_fail, 0);
    a_fin = 0; tick();
    chk("bb_idle", a_busy, 0);

    // Reset mid-attempt
    a_start = 4'b0001; tick();
    a_start = 0; a_cond = 4'b0001; tick();
    chk("mr_busy_before", a_busy, 4'b0001);
    rst_n = 0; #1;
    chk("mr_busy", a_busy, 0);
    chk("mr_fcount", a_fcount, 0);
    a_cond = 0; tick();
    rst_n = 1; tick(); tick();
    chk("mr_nopass", a_pass, 0);
    chk("mr_nofail", a_fail, 0);
    chk("mr_idle", a_busy, 0);

    // en=0 mid-attempt and start while disabled
    a_start = 4'b1000; tick();
    a_start = 0; a_cond = 4'b1000; tick();
    a_en = 0; tick();
    chk("en_idle", a_busy, 0);
    chk("en_nofail", a_fail, 0);
    a_cond = 0; a_start = 4'b1000; tick();
    chk("en_ignored", a_busy, 0);
    chk("en_nodrop", a_dropped, 0);
    chk("en_nofail2", a_fail, 0);
    a_start = 0; a_en = 1; tick();

    // clr coinciding with a fail pulse
    a_start = 4'b0010; tick();
    a_start = 0; tick();
    chk("clr_fail1", a_fail, 4'b0010);
    tick();
    chk("clr_cnt1", a_fcount[31:16], 1);
    a_start = 4'b0010; tick();
    a_start = 0; tick();
    chk("clr_fail2", a_fail, 4'b0010);
    a_clr = 1; tick();
    chk("clr_wins", a_fcount[31:16], 0);
    a_clr = 0;

    // Unbounded REP_MIN=0, CNT_W=3
    b_start = 1; tick();
    b_start = 0; b_fin = 1; tick();
    chk("unb_pass0", b_pass, 1);
    b_fin = 0; b_start = 1; tick();
    b_start = 0; b_cond = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("unb_busy", b_busy, 1);
    end
    b_cond = 0; b_fin = 1; tick();
    chk("unb_pass10", b_pass, 1);
    chk("unb_nofail", b_fail, 0);
    b_fin = 0; tick();

    // 2-bit failure counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      c_start = 1; tick();
      c_start = 0; tick();
      chk("sat_fail", c_fail, 1);
      tick();
      chk("sat_fcount", c_fcount, (i < 3) ? (i + 1) : 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_rep_checker.md
Name: seq_rep_checker

Overview:
- Synthesizable, multi-channel monitor for the bounded consecutive-repetition sequence `start ##1 cond[*MIN:MAX] ##1 fin`.
- Used as a hardware checker alongside the simulation assertion experiments. It gives a gate-level equivalent of `[*m:n]` checks that simulators disagree on.
- Each channel runs one attempt at a time. It reports pass/fail pulses with a cause code and keeps a saturating failure count.

Parameters:
- NCH, 4, number of independent channels.
- CNT_W, 8, width of each channel's repetition counter.
- REP_MIN, 3, minimum consecutive cond cycles (may be 0).
- REP_MAX, 4, maximum consecutive cond cycles. 0 means unbounded (`[*REP_MIN:$]`).
- FCNT_W, 16, width of each saturating failure counter.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when low, all channels are forced idle.
- clr  in  1  synchronous clear of all failure counters.
- start  in  NCH  per-channel attempt trigger.
- cond  in  NCH  per-channel repeated condition.
- fin  in  NCH  per-channel sequence terminator.
- busy  out  NCH  channel has an attempt in progress.
- pass  out  NCH  one-cycle pass pulse.
- fail  out  NCH  one-cycle fail pulse.
- cause  out  2*NCH  fail cause per channel, valid with fail.
- dropped  out  NCH  one-cycle pulse: start ignored while busy.
- fcount  out  FCNT_W*NCH  saturating failure count per channel.

Behaviour:
- Reset (async, rst_n=0): every channel goes to IDLE with counter 0. All outputs are 0, including fcount.
- Elaboration error if REP_MAX!=0 and REP_MIN>REP_MAX. Elaboration error if either bound exceeds 2^CNT_W-1.
- Per-channel FSM has two states, IDLE and RUN.
  - IDLE: start=1 and en=1 → RUN with cnt=0; busy=1 from the next cycle.
  - RUN, evaluated each cycle in this priority order:
    1. en=0 → IDLE, no report.
    2. fin=1 → decide: pass if REP_MIN<=cnt and (REP_MAX==0 or cnt<=REP_MAX); otherwise fail with cause UNDER (2'b11). cond is ignored in the fin cycle.
    3. cond=1 → cnt+1. If REP_MAX!=0 and cnt+1>REP_MAX, fail with cause OVER (2'b10) immediately. In unbounded mode cnt saturates at 2^CNT_W-1.
    4. cond=0 → fail with cause BREAK (2'b01).
  - Any decision returns the channel to IDLE.
- Reporting latency: pass, fail and cause are registered and assert the cycle after the decision cycle, for exactly one cycle. cause is 0 when fail=0.
- Back-to-back attempts: start=1 in a decision cycle re-arms the channel. The next state is RUN with cnt=0 and busy stays 1; this is not a drop.
- start=1 in a non-deciding RUN cycle raises dropped the next cycle. The attempt in progress is unaffected.
- start with en=0 is ignored silently.
- REP_MIN=0: fin in the first RUN cycle passes.
- fcount increments on each registered fail pulse and saturates at all-ones.
  - clr zeroes fcount next cycle.
  - If clr and a fail coincide, the count becomes 0 (clr wins).
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset asserted mid-attempt aborts it with no report.

Decomposition:
- Package seq_chk_pkg holds:
  - state enum: IDLE, RUN.
  - cause enum: NONE=0, BREAK=1, OVER=2, UNDER=3.
  - CAUSE_W=2 constant.
- Sub-module seq_rep_chan implements one channel: FSM, counter, result registers and saturating fcount.
- The top instantiates it NCH times via generate and packs the vectors.

Test Plan:
- Defaults (3:4), ch0: start@t0, cond=1 for t1..t3, fin@t4 → pass[0]=1 at t5 only; busy[0] high t1..t4.
- Defaults, ch1: start, then cond high for 5 cycles with no fin → fail[1] one cycle after the 5th cond; cause=OVER; fcount[1]=1.
- Defaults, ch2: start, cond high 2 cycles then fin → fail with cause UNDER. Then start, cond 1 cycle, then cond=0 → fail with cause BREAK; fcount=2.
- Back-to-back on ch0: start asserted in the fin cycle of a passing attempt → pass pulse, busy stays 1, second attempt passes normally. A start mid-attempt → dropped pulse, no change to cnt.
- REP_MAX=0, REP_MIN=0, CNT_W=3: fin right after start → pass. cond held 10 cycles then fin → pass (cnt saturated at 7).
- Force fcount to all-ones, then fail → stays all-ones. clr coinciding with a fail → 0. rst_n low mid-RUN → all outputs 0 immediately, no pulse after release. en=0 mid-RUN → idle, no report.
